// File: rtl/vdp_bus_master_if.sv
// vdp_bus_master_if
//   Bundles the command/response handshake and the V9958 CPU-port pins
//   driven by vdp_bus_master.
//   master : the initiator (vdp_bus_master) side
//   slave  : the command source / VDP pin side (bench, boot sequencer)
//
//   cmd_valid/cmd_ready   command handshake
//   cmd_op[2:0]           0 REG_WR, 1 VRAM_WADDR, 2 VRAM_RADDR, 3 DATA_WR,
//                         4 DATA_RD, 5 STATUS_RD, 6-7 illegal
//   cmd_reg[5:0]          register / status number
//   cmd_addr[16:0]        VRAM address
//   cmd_data[7:0]         write data
//   rsp_valid/rsp_data    read result pulse / held read data
//   busy                  command in progress
//   mode/csw_n/csr_n/cdo  VDP port pins out, cdi read data in
interface vdp_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [5:0]  cmd_reg;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [1:0]  mode;
  logic        csw_n;
  logic        csr_n;
  logic [7:0]  cdo;
  logic [7:0]  cdi;

  modport master (
    input  cmd_valid, cmd_op, cmd_reg, cmd_addr, cmd_data, cdi,
    output cmd_ready, rsp_valid, rsp_data, busy, mode, csw_n, csr_n, cdo
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_reg, cmd_addr, cmd_data, cdi,
    input  cmd_ready, rsp_valid, rsp_data, busy, mode, csw_n, csr_n, cdo
  );
endinterface

// File: rtl/vdp_bus_master.sv
// vdp_bus_master
//   CPU-side initiator for the V9958 I/O ports. Expands a high-level command
//   into up to five port micro-ops and runs each one as a timed bus cycle
//   SETUP -> STROBE -> HOLD -> RECOVER. Read data is captured from cdi on the
//   last strobe cycle and returned with a one-cycle rsp_valid pulse.
//
//   Ports:
//     clk    pixel clock
//     reset  synchronous, active high
//     bus    vdp_bus_master_if.master (command, response and VDP pins)
//
//   Build option:
//     VDPM_R14_EN  when defined, VRAM address commands first write R#14 with
//                  addr[16:14] (4 micro-ops, 128 KB reach); otherwise they are
//                  2 micro-ops and addr[16:14] is ignored.
//
//   Phase lengths must each be in 1..256 (8-bit phase counter).
module vdp_bus_master #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned RECOVERY_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  vdp_bus_master_if.master bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSetup   = 3'd1;
  localparam logic [2:0] StStrobe  = 3'd2;
  localparam logic [2:0] StHold    = 3'd3;
  localparam logic [2:0] StRecover = 3'd4;

  localparam logic [2:0] OpRegWr     = 3'd0;
  localparam logic [2:0] OpVramWaddr = 3'd1;
  localparam logic [2:0] OpVramRaddr = 3'd2;
  localparam logic [2:0] OpDataWr    = 3'd3;
  localparam logic [2:0] OpDataRd    = 3'd4;
  localparam logic [2:0] OpStatusRd  = 3'd5;

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] SetupLast   = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLast  = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] RecoverLast = CntW'(RECOVERY_CYC - 1);

`ifdef VDPM_R14_EN
  localparam logic [2:0] AddrUops = 3'd4;
  localparam logic [2:0] AddrBase = 3'd0;
`else
  // Skipping the R#14 prefix: address micro-op table starts at entry 2.
  localparam logic [2:0] AddrUops = 3'd2;
  localparam logic [2:0] AddrBase = 3'd2;
`endif

  function automatic logic [2:0] uop_count(input logic [2:0] op);
    case (op)
      OpRegWr:                  return 3'd2;
      OpVramWaddr, OpVramRaddr: return AddrUops;
      OpDataWr, OpDataRd:       return 3'd1;
      OpStatusRd:               return 3'd5;
      default:                  return 3'd0;
    endcase
  endfunction

  // Micro-op encoding: {is_read, port, byte}.
  function automatic logic [9:0] uop_decode(input logic [2:0]  op,
                                            input logic [5:0]  rnum,
                                            input logic [16:0] addr,
                                            input logic [7:0]  data,
                                            input logic [2:0]  idx);
    logic [2:0] aidx;
    logic [9:0] u;
    aidx = idx + AddrBase;
    u    = '0;
    case (op)
      OpRegWr: u = (idx == 3'd0) ? {2'b01, data} : {2'b01, 2'b10, rnum};
      OpVramWaddr, OpVramRaddr: begin
        case (aidx)
          3'd0:    u = {2'b01, 5'b00000, addr[16:14]};
          3'd1:    u = {2'b01, 8'h8E};
          3'd2:    u = {2'b01, addr[7:0]};
          default: u = {2'b01, (op == OpVramWaddr) ? 2'b01 : 2'b00, addr[13:8]};
        endcase
      end
      OpDataWr: u = {2'b00, data};
      OpDataRd: u = {2'b10, 8'h00};
      OpStatusRd: begin
        // Select S#n, read it, then point R#15 back at S#0.
        case (idx)
          3'd0:    u = {2'b01, 2'b00, rnum};
          3'd1:    u = {2'b01, 8'h8F};
          3'd2:    u = {2'b11, 8'h00};
          3'd3:    u = {2'b01, 8'h00};
          default: u = {2'b01, 8'h8F};
        endcase
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      nuop_q, nuop_d;
  logic [2:0]      op_q, op_d;
  logic [5:0]      reg_q, reg_d;
  logic [16:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            rd_q, rd_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      cdo_q, cdo_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [2:0] first_n;
  logic [9:0] first_uop;
  logic [9:0] next_uop;

  always_comb begin
    first_n   = uop_count(bus.cmd_op);
    first_uop = uop_decode(bus.cmd_op, bus.cmd_reg, bus.cmd_addr, bus.cmd_data, 3'd0);
    next_uop  = uop_decode(op_q, reg_q, addr_q, data_q, idx_q + 3'd1);

    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nuop_d      = nuop_q;
    op_d        = op_q;
    reg_d       = reg_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_d        = rd_q;
    mode_d      = mode_q;
    cdo_d       = cdo_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          reg_d  = bus.cmd_reg;
          addr_d = bus.cmd_addr;
          data_d = bus.cmd_data;
          nuop_d = first_n;
          // Illegal ops decode to zero micro-ops and are simply dropped.
          if (first_n != 3'd0) begin
            state_d = StSetup;
            cnt_d   = '0;
            idx_d   = 3'd0;
            rd_d    = first_uop[9];
            mode_d  = {1'b0, first_uop[8]};
            if (!first_uop[9]) cdo_d = first_uop[7:0];
          end
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          if (rd_q) rsp_data_d = bus.cdi;
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StRecover;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == RecoverLast) begin
          cnt_d = '0;
          if (idx_q == nuop_q - 3'd1) begin
            state_d     = StIdle;
            rsp_valid_d = (op_q == OpDataRd) || (op_q == OpStatusRd);
          end else begin
            state_d = StSetup;
            idx_d   = idx_q + 3'd1;
            rd_d    = next_uop[9];
            mode_d  = {1'b0, next_uop[8]};
            if (!next_uop[9]) cdo_d = next_uop[7:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      nuop_q      <= '0;
      op_q        <= '0;
      reg_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= 1'b0;
      mode_q      <= 2'b00;
      cdo_q       <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nuop_q      <= nuop_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      mode_q      <= mode_d;
      cdo_q       <= cdo_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Strobes decode from registered state only, so they cannot both be low.
  assign bus.cmd_ready = (state_q == StIdle) & ~reset;
  assign bus.busy      = (state_q != StIdle);
  assign bus.csw_n     = ~((state_q == StStrobe) & ~rd_q);
  assign bus.csr_n     = ~((state_q == StStrobe) & rd_q);
  assign bus.mode      = mode_q;
  assign bus.cdo       = cdo_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vdp_bus_master.sv
module tb_vdp_bus_master;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rd_val;

  vdp_bus_master_if bus();

  vdp_bus_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // VDP model: read data only valid while the read strobe is low.
  assign bus.cdi = bus.csr_n ? 8'h00 : rd_val;

  typedef struct packed {
    logic        rd;
    logic [1:0]  mode;
    logic [7:0]  cdo;
    logic [31:0] len;
    logic [31:0] t0;
  } pulse_t;

  pulse_t      pulses[$];
  int unsigned gaps[$];
  logic [10:0] exp_q[$];
  pulse_t      cur;
  int unsigned cyc = 0, busy_cnt = 0, rsp_cnt = 0, overlap_cnt = 0, chg_cnt = 0;
  int unsigned acc_cyc = 0, rsp_cyc = 0, last_low = 0;
  logic [7:0]  rsp_seen = 8'h00;
  bit          in_stb = 1'b0, have_prev = 1'b0;
  int          errors = 0, checks = 0;
  int          p0, b0, r0;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!bus.csw_n && !bus.csr_n) overlap_cnt = overlap_cnt + 1;
    if (bus.busy) busy_cnt = busy_cnt + 1;
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
    if (bus.rsp_valid) begin
      rsp_cnt  = rsp_cnt + 1;
      rsp_cyc  = cyc;
      rsp_seen = bus.rsp_data;
    end
    if (!bus.csw_n || !bus.csr_n) begin
      if (!in_stb) begin
        in_stb   = 1'b1;
        cur.rd   = !bus.csr_n;
        cur.mode = bus.mode;
        cur.cdo  = bus.cdo;
        cur.len  = 0;
        cur.t0   = cyc;
        if (have_prev) gaps.push_back(cyc - last_low - 1);
      end else if (bus.mode !== cur.mode || bus.cdo !== cur.cdo) begin
        chg_cnt = chg_cnt + 1;
      end
      cur.len   = cur.len + 1;
      last_low  = cyc;
      have_prev = 1'b1;
    end else if (in_stb) begin
      in_stb = 1'b0;
      pulses.push_back(cur);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares pulses logged since index 'base' against exp_q ({rd, mode, cdo}).
  task automatic check_pulses(input string tag, input int base);
    check_eq({tag, "_count"}, 32'(pulses.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i),
               32'({pulses[base+i].rd, pulses[base+i].mode, pulses[base+i].cdo}),
               32'(exp_q[i]));
      check_eq($sformatf("%s_%0d_len", tag, i), pulses[base+i].len, 32'd4);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [5:0] rn,
                      input logic [16:0] addr, input logic [7:0] data);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_reg   = rn;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble fields to show they were latched at acceptance.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_reg   = ~rn;
    bus.cmd_addr  = ~addr;
    bus.cmd_data  = ~data;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    rd_val        = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_reg   = 6'd0;
    bus.cmd_addr  = 17'd0;
    bus.cmd_data  = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_csw_n", 32'(bus.csw_n), 32'd1);
    check_eq("rst_csr_n", 32'(bus.csr_n), 32'd1);
    check_eq("rst_mode", 32'(bus.mode), 32'd0);
    check_eq("rst_cdo", 32'(bus.cdo), 32'h00);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // REG_WR reg 7, data F4
    p0 = pulses.size(); b0 = busy_cnt; r0 = rsp_cnt;
    send(3'd0, 6'd7, 17'h0, 8'hF4);
    wait_idle();
    exp_q = '{{1'b0, 2'b01, 8'hF4}, {1'b0, 2'b01, 8'h87}};
    check_pulses("regwr", p0);
    check_eq("regwr_first_strobe", pulses[p0].t0, 32'(acc_cyc + 3));
    check_eq("regwr_busy", 32'(busy_cnt - b0), 32'd24);
    check_eq("regwr_rsp", 32'(rsp_cnt - r0), 32'd0);

    // VRAM_WADDR 0x1ABCD
    p0 = pulses.size();
    send(3'd1, 6'd0, 17'h1ABCD, 8'h00);
    wait_idle();
`ifdef VDPM_R14_EN
    exp_q = '{{1'b0, 2'b01, 8'h06}, {1'b0, 2'b01, 8'h8E},
              {1'b0, 2'b01, 8'hCD}, {1'b0, 2'b01, 8'h6B}};
`else
    exp_q = '{{1'b0, 2'b01, 8'hCD}, {1'b0, 2'b01, 8'h6B}};
`endif
    check_pulses("waddr", p0);

    // VRAM_RADDR 0x1ABCD
    p0 = pulses.size();
    send(3'd2, 6'd0, 17'h1ABCD, 8'h00);
    wait_idle();
`ifdef VDPM_R14_EN
    exp_q = '{{1'b0, 2'b01, 8'h06}, {1'b0, 2'b01, 8'h8E},
              {1'b0, 2'b01, 8'hCD}, {1'b0, 2'b01, 8'h2B}};
`else
    exp_q = '{{1'b0, 2'b01, 8'hCD}, {1'b0, 2'b01, 8'h2B}};
`endif
    check_pulses("raddr", p0);

    // DATA_RD, cdi 5A; cdo keeps the last written byte
    p0 = pulses.size(); r0 = rsp_cnt;
    rd_val = 8'h5A;
    send(3'd4, 6'd0, 17'h0, 8'h00);
    wait_idle();
    exp_q = '{{1'b1, 2'b00, 8'h2B}};
    check_pulses("datard", p0);
    check_eq("datard_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    check_eq("datard_rsp_cycle", 32'(rsp_cyc - acc_cyc), 32'd13);
    check_eq("datard_rsp_seen", 32'(rsp_seen), 32'h5A);
    check_eq("datard_rsp_held", 32'(bus.rsp_data), 32'h5A);

    // STATUS_RD status 2, cdi 9F
    p0 = pulses.size(); b0 = busy_cnt; r0 = rsp_cnt;
    rd_val = 8'h9F;
    send(3'd5, 6'd2, 17'h0, 8'h00);
    wait_idle();
    exp_q = '{{1'b0, 2'b01, 8'h02}, {1'b0, 2'b01, 8'h8F}, {1'b1, 2'b01, 8'h8F},
              {1'b0, 2'b01, 8'h00}, {1'b0, 2'b01, 8'h8F}};
    check_pulses("status", p0);
    check_eq("status_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    check_eq("status_rsp_seen", 32'(rsp_seen), 32'h9F);
    check_eq("status_busy", 32'(busy_cnt - b0), 32'd60);

    // Reset during the 2nd strobe cycle of DATA_WR
    p0 = pulses.size(); r0 = rsp_cnt;
    send(3'd3, 6'd0, 17'h0, 8'h33);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_strobe_low", 32'(bus.csw_n), 32'd0);
    check_eq("midrst_cdo_before", 32'(bus.cdo), 32'h33);
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_csw_n", 32'(bus.csw_n), 32'd1);
    check_eq("midrst_cdo", 32'(bus.cdo), 32'h00);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check_eq("midrst_pulses", 32'(pulses.size() - p0), 32'd1);
    check_eq("midrst_rsp", 32'(rsp_cnt - r0), 32'd0);

    // Back-to-back DATA_WR with valid held, then illegal op 6
    p0 = pulses.size(); r0 = rsp_cnt;
    send(3'd3, 6'd0, 17'h0, 8'h11);
    send(3'd3, 6'd0, 17'h0, 8'h22);
    send(3'd6, 6'd0, 17'h0, 8'h00);
    @(negedge clk);
    check_eq("illegal_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("illegal_busy", 32'(bus.busy), 32'd0);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    exp_q = '{{1'b0, 2'b00, 8'h11}, {1'b0, 2'b00, 8'h22}};
    check_pulses("b2b", p0);
    check_eq("b2b_gap_ge5", 32'(gaps[gaps.size()-1] >= 5), 32'd1);
    check_eq("b2b_rsp", 32'(rsp_cnt - r0), 32'd0);
    check_eq("strobe_overlap", overlap_cnt, 32'd0);
    check_eq("strobe_bus_change", chg_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
